// File: rtl/rv32_hpm_bank.sv
// Bank of RISC-V machine HPM counters with per-counter event select, inhibit,
// sticky overflow flag and registered overflow interrupt.
module rv32_hpm_bank #(
    parameter int unsigned NUM_COUNTERS  = 4,
    parameter int unsigned NUM_EVENTS    = 8,
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [11:0]           read_id,
    output logic [31:0]           read_value,
    output logic                  read_hit,
    input  logic                  write_en,
    input  logic [11:0]           write_id,
    input  logic [31:0]           write_value,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic [31:0]           mcountinhibit,
    output logic                  overflow_irq
);

    logic [COUNTER_WIDTH-1:0] cnt [NUM_COUNTERS];
    logic [4:0]               sel [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  of_flag;
    logic [NUM_COUNTERS-1:0]  ovfie;
    logic [NUM_COUNTERS-1:0]  wr_lo, wr_hi, wr_ev, inc;
    logic [31:0]              ev_ext;
    logic [4:0]               sel_wr;
    logic [63:0]              ext;
    logic                     unused_inhibit;

    assign unused_inhibit = ^mcountinhibit;

    // SEL is WARL: out-of-range selections collapse to 0 (count nothing)
    assign sel_wr = (write_value[4:0] > 5'(NUM_EVENTS)) ? '0 : write_value[4:0];

    // Bit e of ev_ext is event e so SEL can index it directly; bit 0 stays 0
    always_comb begin
        ev_ext = '0;
        ev_ext[NUM_EVENTS:1] = events;
    end

    always_comb begin
        wr_lo = '0;
        wr_hi = '0;
        wr_ev = '0;
        inc   = '0;
        for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
            wr_lo[k] = write_en && (write_id == 12'(12'hB03 + k));
            wr_hi[k] = write_en && (write_id == 12'(12'hB83 + k));
            wr_ev[k] = write_en && (write_id == 12'(12'h323 + k));
            inc[k]   = ev_ext[sel[k]] && !mcountinhibit[3+k] && !wr_lo[k] && !wr_hi[k];
        end
    end

    always_comb begin
        read_value = '0;
        read_hit   = 1'b0;
        ext        = '0;
        for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
            if (read_id == 12'(12'hB03 + k)) begin
                read_value = cnt[k][31:0];
                read_hit   = 1'b1;
            end else if (read_id == 12'(12'hB83 + k)) begin
                ext        = 64'(cnt[k]);
                read_value = ext[63:32];
                read_hit   = 1'b1;
            end else if (read_id == 12'(12'h323 + k)) begin
                read_value = {of_flag[k], ovfie[k], 25'b0, sel[k]};
                read_hit   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            of_flag      <= '0;
            ovfie        <= '0;
            overflow_irq <= 1'b0;
            for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
                cnt[k] <= '0;
                sel[k] <= '0;
            end
        end else begin
            overflow_irq <= |(of_flag & ovfie);
            for (int unsigned k = 0; k < NUM_COUNTERS; k++) begin
                if (wr_lo[k])
                    cnt[k][31:0] <= write_value;
                else if (wr_hi[k])
                    cnt[k][COUNTER_WIDTH-1:32] <= write_value[COUNTER_WIDTH-33:0];
                else if (inc[k])
                    cnt[k] <= cnt[k] + COUNTER_WIDTH'(1);
                // An mhpmevent write overrides a same-cycle wrap
                if (wr_ev[k]) begin
                    of_flag[k] <= write_value[31];
                    ovfie[k]   <= write_value[30];
                    sel[k]     <= sel_wr;
                end else if (inc[k] && (&cnt[k])) begin
                    of_flag[k] <= 1'b1;
                end
            end
        end
    end

endmodule
